// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the four-approach traffic phase
//               arbiter: 2-bit light codes and the controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Per-approach light codes as driven on the light bus
    localparam logic [1:0] c_RED    = 2'd0;
    localparam logic [1:0] c_YELLOW = 2'd1;
    localparam logic [1:0] c_GREEN  = 2'd2;

    // Controller states, explicitly encoded
    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Returns the first
//               approach j != cur with req[j]=1, searching cur+1, cur+2,
//               cur+3 (mod 4).
// Ports       : req   [3:0] in  - per-approach request levels
//               cur   [1:0] in  - approach currently holding the phase
//               idx   [1:0] out - selected approach (cur when none found)
//               found       out - some other approach is requesting
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import traffic_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] cur,
    output logic [1:0] idx,
    output logic       found
);

    logic [1:0] w_cand;

    // Scan from the farthest offset down to the nearest so that the
    // nearest requesting approach is the final (winning) assignment.
    always_comb begin
        idx    = cur;
        found  = 1'b0;
        w_cand = cur;
        for (int k = 3; k >= 1; k--) begin
            w_cand = cur + 2'(k);
            if (req[w_cand]) begin
                idx   = w_cand;
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_arbiter
// Description : Four-approach traffic light controller. Cycles
//               GREEN -> YELLOW -> ALLRED -> GREEN, handing green to the next
//               requesting approach in round-robin order, with min/max green
//               limits and emergency-vehicle preemption.
// Ports       : clock            in  - single clock, posedge
//               clear            in  - asynchronous active-high reset
//               req         [3:0] in  - car-sensor request per approach
//               emerg_valid      in  - emergency preemption request
//               emerg_dir   [1:0] in  - approach to preempt to
//               light       [7:0] out - light[2i+1:2i] for approach i
//               phase       [1:0] out - approach owning green/yellow
//               phase_start      out - pulse on first cycle of each green
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] req,
    input  logic       emerg_valid,
    input  logic [1:0] emerg_dir,
    output logic [7:0] light,
    output logic [1:0] phase,
    output logic       phase_start
);

    // Last timer value of each interval (timer counts from 0)
    localparam logic [7:0] c_min_last    = 8'(MIN_GREEN - 1);
    localparam logic [7:0] c_max_last    = 8'(MAX_GREEN - 1);
    localparam logic [7:0] c_yellow_last = 8'(YELLOW_T - 1);
    localparam logic [7:0] c_allred_last = 8'(ALLRED_T - 1);

    state_t     r_state;
    logic [1:0] r_cur;
    logic [1:0] r_nxt;
    logic [7:0] r_timer;

    logic [1:0] w_rr_idx;
    logic       w_waiting;
    logic [7:0] w_timer_inc;
    logic       w_green_exit;

    // A requesting approach other than cur exists exactly when the
    // round-robin scan finds one.
    rr_pick u_rr_pick (
        .req   (req),
        .cur   (r_cur),
        .idx   (w_rr_idx),
        .found (w_waiting)
    );

    assign w_timer_inc  = (r_timer == 8'hFF) ? r_timer : r_timer + 8'd1;

    assign w_green_exit = w_waiting &&
                          (((r_timer >= c_min_last) && !req[r_cur]) ||
                           (r_timer >= c_max_last));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state <= S_GREEN;
            r_cur   <= 2'd0;
            r_nxt   <= 2'd0;
            r_timer <= 8'd0;
        end else begin
            case (r_state)
                S_GREEN: begin
                    // Any emergency request takes precedence over the normal
                    // timer exit; one aimed at cur pins the green.
                    if (emerg_valid && (emerg_dir != r_cur)) begin
                        r_state <= S_YELLOW;
                        r_nxt   <= emerg_dir;
                        r_timer <= 8'd0;
                    end else if (!emerg_valid && w_green_exit) begin
                        r_state <= S_YELLOW;
                        r_nxt   <= w_rr_idx;
                        r_timer <= 8'd0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                S_YELLOW: begin
                    if (emerg_valid) begin
                        r_nxt <= emerg_dir;
                    end
                    if (r_timer == c_yellow_last) begin
                        r_state <= S_ALLRED;
                        r_timer <= 8'd0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                S_ALLRED: begin
                    if (emerg_valid) begin
                        r_nxt <= emerg_dir;
                    end
                    if (r_timer == c_allred_last) begin
                        r_state <= S_GREEN;
                        r_timer <= 8'd0;
                        // An emergency request in the final clearance cycle
                        // still redirects the upcoming green.
                        r_cur   <= emerg_valid ? emerg_dir : r_nxt;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end

                default: begin
                    r_state <= S_GREEN;
                    r_timer <= 8'd0;
                end
            endcase
        end
    end

    // Output decode: only cur may be non-red, and only in GREEN/YELLOW.
    always_comb begin
        light = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_cur == 2'(i)) begin
                if (r_state == S_GREEN) begin
                    light[2*i +: 2] = c_GREEN;
                end else if (r_state == S_YELLOW) begin
                    light[2*i +: 2] = c_YELLOW;
                end else begin
                    light[2*i +: 2] = c_RED;
                end
            end
        end
    end

    assign phase = r_cur;

    // The timer saturates rather than wraps, so timer==0 in GREEN occurs only
    // in the first cycle of a green interval. Gating with clear keeps the
    // pulse low while reset is held.
    assign phase_start = (r_state == S_GREEN) && (r_timer == 8'd0) && !clear;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_arbiter
// Description : Directed self-checking bench for traffic_phase_arbiter with
//               default timing (MIN 4, MAX 10, YELLOW 3, ALLRED 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_arbiter;

    logic       clock;
    logic       clear;
    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_dir;
    logic [7:0] light;
    logic [1:0] phase;
    logic       phase_start;

    int n_vec;
    int n_err;

    traffic_phase_arbiter #(
        .MIN_GREEN (4),
        .MAX_GREEN (10),
        .YELLOW_T  (3),
        .ALLRED_T  (2)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .emerg_valid (emerg_valid),
        .emerg_dir   (emerg_dir),
        .light       (light),
        .phase       (phase),
        .phase_start (phase_start)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one cycle; sample/drive 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Check light (and optionally phase) for n consecutive cycles.
    task automatic expect_run(input string tag, input int n, input logic [7:0] exp_light,
                              input bit chk_phase, input logic [1:0] exp_phase);
        for (int i = 0; i < n; i++) begin
            check_vec(tag, {24'd0, light}, {24'd0, exp_light});
            if (chk_phase) check_vec({tag, "_phase"}, {30'd0, phase}, {30'd0, exp_phase});
            step();
        end
    endtask

    // Hold clear for two edges, then release; returns in cycle 0.
    task automatic do_reset(input logic [3:0] r);
        clear       = 1'b1;
        req         = r;
        emerg_valid = 1'b0;
        emerg_dir   = 2'd0;
        #1;
        check_vec("rst_light", {24'd0, light}, 32'h02);
        check_vec("rst_phase", {30'd0, phase}, 32'd0);
        check_vec("rst_pstart", {31'd0, phase_start}, 32'd0);
        step();
        step();
        clear = 1'b0;
        #1;
        check_vec("rel_pstart", {31'd0, phase_start}, 32'd1);
        check_vec("rel_light", {24'd0, light}, 32'h02);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        clear       = 1'b0;
        req         = 4'd0;
        emerg_valid = 1'b0;
        emerg_dir   = 2'd0;
        #1;

        // Single other request, approach 0 idle: min-green exit to approach 2
        do_reset(4'b0100);
        expect_run("t1_green0", 4, 8'h02, 1'b1, 2'd0);
        check_vec("t1_pstart_y", {31'd0, phase_start}, 32'd0);
        expect_run("t1_yel0", 3, 8'h01, 1'b1, 2'd0);
        expect_run("t1_allred", 2, 8'h00, 1'b0, 2'd0);
        check_vec("t1_green2", {24'd0, light}, 32'h20);
        check_vec("t1_phase2", {30'd0, phase}, 32'd2);
        check_vec("t1_pstart2", {31'd0, phase_start}, 32'd1);

        // Approach 0 still requesting: max-green exit to approach 1
        do_reset(4'b0011);
        expect_run("t2_green0", 10, 8'h02, 1'b1, 2'd0);
        expect_run("t2_yel0", 3, 8'h01, 1'b1, 2'd0);
        expect_run("t2_allred", 2, 8'h00, 1'b0, 2'd0);
        check_vec("t2_pstart1", {31'd0, phase_start}, 32'd1);
        expect_run("t2_green1", 10, 8'h08, 1'b1, 2'd1);
        expect_run("t2_yel1", 1, 8'h04, 1'b1, 2'd1);
        // Mid-yellow of approach 1: asynchronous clear between edges
        check_vec("t2_midyel", {24'd0, light}, 32'h04);
        #1;
        clear = 1'b1;
        #1;
        check_vec("t2_async_light", {24'd0, light}, 32'h02);
        check_vec("t2_async_phase", {30'd0, phase}, 32'd0);
        check_vec("t2_async_pstart", {31'd0, phase_start}, 32'd0);

        // Round-robin wrap: from approach 3 with req 0011 pick 0, not 1
        do_reset(4'b1000);
        expect_run("t3_green0", 4, 8'h02, 1'b1, 2'd0);
        expect_run("t3_yel0", 3, 8'h01, 1'b1, 2'd0);
        expect_run("t3_allred", 2, 8'h00, 1'b0, 2'd0);
        req = 4'b0011;
        expect_run("t3_green3", 4, 8'h80, 1'b1, 2'd3);
        expect_run("t3_yel3", 3, 8'h40, 1'b1, 2'd3);
        expect_run("t3_allred2", 2, 8'h00, 1'b0, 2'd0);
        check_vec("t3_wrap_light", {24'd0, light}, 32'h02);
        check_vec("t3_wrap_phase", {30'd0, phase}, 32'd0);

        // Emergency preemption at timer=1, overriding MIN_GREEN and req
        do_reset(4'b0011);
        expect_run("t4_green0", 1, 8'h02, 1'b1, 2'd0);
        emerg_valid = 1'b1;
        emerg_dir   = 2'd2;
        expect_run("t4_emerg_c1", 1, 8'h02, 1'b1, 2'd0);
        emerg_valid = 1'b0;
        expect_run("t4_yel0", 3, 8'h01, 1'b1, 2'd0);
        expect_run("t4_allred", 2, 8'h00, 1'b0, 2'd0);
        check_vec("t4_green2", {24'd0, light}, 32'h20);
        check_vec("t4_phase2", {30'd0, phase}, 32'd2);
        check_vec("t4_pstart2", {31'd0, phase_start}, 32'd1);

        // Emergency to the current approach holds green beyond MAX_GREEN
        emerg_valid = 1'b1;
        emerg_dir   = 2'd2;
        expect_run("t5_hold", 15, 8'h20, 1'b1, 2'd2);
        emerg_valid = 1'b0;
        expect_run("t5_release", 1, 8'h20, 1'b1, 2'd2);
        check_vec("t5_yel2", {24'd0, light}, 32'h10);

        // Idle: green holds, no further pulses, timer saturates (no wrap)
        do_reset(4'b0000);
        for (int i = 1; i <= 264; i++) begin
            step();
            check_vec("t6_idle_light", {24'd0, light}, 32'h02);
            check_vec("t6_idle_pstart", {31'd0, phase_start}, 32'd0);
        end
        req = 4'b0011;
        step();
        check_vec("t6_sat_exit", {24'd0, light}, 32'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
